// File: rtl/lut_dm_ptr.sv
// Indexed DataMem pointer table with post-increment / pre-decrement lookups.
// One-cycle registered lookup, same-cycle writes override the pointer update.
module lut_dm_ptr #(
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 10,
  parameter int BASE   = 64,
  parameter int STRIDE = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RdEn,
  input  logic [IDX_W-1:0]  Addr,
  input  logic [1:0]        Mode,
  input  logic              WrEn,
  input  logic [IDX_W-1:0]  WrIdx,
  input  logic [ADDR_W-1:0] WrData,
  output logic [ADDR_W-1:0] Target,
  output logic              Valid
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    M_PLAIN = 2'b00,
    M_POST  = 2'b01,
    M_PRE   = 2'b10,
    M_RSVD  = 2'b11
  } mode_t;

  logic [ADDR_W-1:0] tbl [DEPTH];
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] nxt;
  logic [ADDR_W-1:0] res;
  mode_t             mode;

  function automatic logic [ADDR_W-1:0] rst_val(input int i);
    return ADDR_W'(BASE + i * STRIDE);
  endfunction

  assign mode = mode_t'(Mode);
  assign cur  = tbl[Addr];

  always_comb begin
    nxt = cur;
    res = cur;
    unique case (mode)
      M_POST: nxt = cur + ADDR_W'(1);
      M_PRE: begin
        nxt = cur - ADDR_W'(1);
        res = cur - ADDR_W'(1);
      end
      default: begin
        nxt = cur;
        res = cur;
      end
    endcase
  end

  // Write takes precedence over the lookup's pointer update on the same entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= rst_val(i);
      end
      Target <= '0;
      Valid  <= 1'b0;
    end else begin
      Valid <= RdEn;
      if (RdEn) begin
        Target <= res;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (WrEn && WrIdx == IDX_W'(i)) begin
          tbl[i] <= WrData;
        end else if (RdEn && Addr == IDX_W'(i)) begin
          tbl[i] <= nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_lut_dm_ptr.sv
// Scoreboard bench for lut_dm_ptr: default instance plus a narrow
// parameter-sweep instance, each against an array reference model.
module tb_lut_dm_ptr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rd0, wr0, v0;
  logic [2:0] a0, wi0;
  logic [1:0] m0;
  logic [9:0] wd0, t0;

  logic       rst1, rd1, wr1, v1;
  logic [1:0] a1, wi1;
  logic [1:0] m1;
  logic [7:0] wd1, t1;

  lut_dm_ptr dut0 (
    .Clk(clk), .Reset(rst0), .RdEn(rd0), .Addr(a0), .Mode(m0),
    .WrEn(wr0), .WrIdx(wi0), .WrData(wd0), .Target(t0), .Valid(v0)
  );

  lut_dm_ptr #(.IDX_W(2), .ADDR_W(8), .BASE(250), .STRIDE(3)) dut1 (
    .Clk(clk), .Reset(rst1), .RdEn(rd1), .Addr(a1), .Mode(m1),
    .WrEn(wr1), .WrIdx(wi1), .WrData(wd1), .Target(t1), .Valid(v1)
  );

  int nvec = 0;
  int nerr = 0;
  int q0[$];
  int q1[$];
  int model [2][8];
  int last [2];
  bit in_rst [2];
  int mask [2]   = '{1023, 255};
  int depth [2]  = '{8, 4};
  int base [2]   = '{64, 250};
  int stride [2] = '{1, 3};

  task automatic push(int u, int e);
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic drive(int u, bit r, bit rd, int a, int md,
                       bit wr, int wi, int wd);
    int old, nv, e;
    @(negedge clk);
    rst0 = (u == 0) && r;  rd0 = (u == 0) && rd;  wr0 = (u == 0) && wr;
    rst1 = (u == 1) && r;  rd1 = (u == 1) && rd;  wr1 = (u == 1) && wr;
    a0 = 3'(a); wi0 = 3'(wi); m0 = 2'(md); wd0 = 10'(wd);
    a1 = 2'(a); wi1 = 2'(wi); m1 = 2'(md); wd1 = 8'(wd);
    in_rst[0] = rst0;
    in_rst[1] = rst1;
    if (r) begin
      for (int i = 0; i < depth[u]; i++)
        model[u][i] = (base[u] + i * stride[u]) & mask[u];
    end else begin
      if (rd) begin
        old = model[u][a];
        nv = old;
        e = old;
        if (md == 1) nv = (old + 1) & mask[u];
        if (md == 2) begin
          nv = (old - 1) & mask[u];
          e = nv;
        end
        push(u, e);
        model[u][a] = nv;
      end
      if (wr) model[u][wi] = wd & mask[u];
    end
  endtask

  task automatic idle(int u);
    drive(u, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(int u, int a, int md);
    drive(u, 0, 1, a, md, 0, 0, 0);
  endtask

  task automatic wr(int u, int wi, int wd);
    drive(u, 0, 0, 0, 0, 1, wi, wd);
  endtask

  task automatic mon(int u);
    bit v;
    int t, e, n;
    logic bad_rst;
    v = (u == 0) ? v0 : v1;
    t = (u == 0) ? int'(t0) : int'(t1);
    bad_rst = (u == 0) ? (v0 !== 1'b0 || t0 !== 10'd0)
                       : (v1 !== 1'b0 || t1 !== 8'd0);
    n = (u == 0) ? q0.size() : q1.size();
    if (in_rst[u]) begin
      nvec++;
      if (bad_rst) begin
        nerr++;
        $display("FAIL reset u%0d: valid=%b target=%0d, need 0/0", u, v, t);
      end
      last[u] = 0;
      if (u == 0) q0.delete();
      else q1.delete();
    end else if (v) begin
      nvec++;
      if (n == 0) begin
        nerr++;
        $display("FAIL spurious_valid u%0d: target=%0d, no lookup pending", u, t);
      end else begin
        if (u == 0) e = q0.pop_front();
        else e = q1.pop_front();
        if (t != e) begin
          nerr++;
          $display("FAIL lookup u%0d: target=%0d, need %0d", u, t, e);
        end
        last[u] = e;
      end
    end else begin
      nvec++;
      if (n != 0) begin
        nerr++;
        $display("FAIL missing_valid u%0d: valid=0, %0d lookups pending", u, n);
        if (u == 0) q0.delete();
        else q1.delete();
      end else if (t != last[u]) begin
        nerr++;
        $display("FAIL hold u%0d: target=%0d, need %0d", u, t, last[u]);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0);
    mon(1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, md, wi, wd;
    bit r, rdq, wrq;
    rst0 = 1; rst1 = 1; rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0;
    a0 = 0; a1 = 0; wi0 = 0; wi1 = 0; m0 = 0; m1 = 0; wd0 = 0; wd1 = 0;
    in_rst[0] = 1; in_rst[1] = 1;
    last[0] = 0; last[1] = 0;
    for (int i = 0; i < 8; i++) begin
      model[0][i] = (64 + i) & 1023;
      model[1][i] = 0;
    end
    for (int i = 0; i < 4; i++) model[1][i] = (250 + 3 * i) & 255;
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) rd(0, i, 0);
    idle(0);
    for (int i = 0; i < 3; i++) rd(0, 2, 1);
    rd(0, 2, 0);
    wr(0, 5, 1023);
    rd(0, 5, 1);
    rd(0, 5, 0);
    wr(0, 5, 0);
    rd(0, 5, 2);
    drive(0, 0, 1, 3, 1, 1, 3, 500);
    rd(0, 3, 0);
    drive(0, 0, 1, 4, 2, 1, 6, 7);
    rd(0, 6, 0);
    rd(0, 4, 3);
    rd(0, 0, 1);
    rd(0, 0, 1);
    drive(0, 1, 1, 0, 1, 1, 0, 99);
    idle(0);
    rd(0, 0, 0);

    drive(1, 1, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) rd(1, i, 0);
    for (int i = 0; i < 3; i++) rd(1, 1, 1);
    rd(1, 1, 0);
    rd(1, 2, 2);
    rd(1, 2, 0);
    drive(1, 0, 1, 0, 1, 1, 0, 255);
    rd(1, 0, 1);
    rd(1, 0, 0);
    idle(1);

    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 59) == 0);
      rdq = ($urandom_range(0, 3) != 0);
      wrq = ($urandom_range(0, 3) == 0);
      a = $urandom_range(0, 7);
      md = $urandom_range(0, 3);
      wi = $urandom_range(0, 1) ? a : $urandom_range(0, 7);
      case ($urandom_range(0, 3))
        0: wd = 1023;
        1: wd = 0;
        default: wd = $urandom_range(0, 1023);
      endcase
      drive(0, r, rdq, a, md, wrq, wi, wd);
    end
    for (int k = 0; k < 200; k++) begin
      r = ($urandom_range(0, 59) == 0);
      rdq = ($urandom_range(0, 3) != 0);
      wrq = ($urandom_range(0, 3) == 0);
      a = $urandom_range(0, 3);
      md = $urandom_range(0, 3);
      wi = $urandom_range(0, 1) ? a : $urandom_range(0, 3);
      wd = $urandom_range(0, 1) ? 255 * $urandom_range(0, 1)
                                : $urandom_range(0, 255);
      drive(1, r, rdq, a, md, wrq, wi, wd);
    end
    idle(0);
    idle(0);
    @(negedge clk);
    nvec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d/%0d lookups left, need 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
